// File: rtl/ble_packet_framer_if.sv
// Byte-stream side of the BLE capture stage: serial receive inputs plus
// the length-prefixed byte output with ready backpressure.
interface ble_packet_framer_if;
  logic       serial_i;
  logic       valid_i;
  logic [6:0] channel_i;
  logic [7:0] rssi_i;
  logic       ready_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_o;
  logic [7:0] drop_cnt_o;

  modport master (output serial_i, valid_i, channel_i, rssi_i, ready_i,
                  input  data_o, valid_o, frame_o, drop_cnt_o);
  modport slave  (input  serial_i, valid_i, channel_i, rssi_i, ready_i,
                  output data_o, valid_o, frame_o, drop_cnt_o);
endinterface

// File: rtl/ble_packet_framer.sv
// BLE advertising capture: access-address hunt, channel filter, store-and-forward
// byte FIFO with tentative/committed write pointers, length-prefixed byte output.
module ble_packet_framer #(
  parameter int          FIFO_DEPTH   = 128,
  parameter logic [31:0] ACCESS_ADDR  = 32'h8E89BED6,
  parameter logic [78:0] CHANNEL_MASK = {79{1'b1}},
  parameter int          MAX_LEN      = 37
) (
  input logic clk_i,
  input logic rst_i,
  ble_packet_framer_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [127:0] MASK_EXT = {49'd0, CHANNEL_MASK};
  typedef logic [AW:0]   ptr_t;
  typedef logic [AW-1:0] addr_t;
  typedef enum logic [1:0] {RX_HUNT, RX_HEADER, RX_PAYLOAD} rx_state_t;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  rx_state_t rx_state, rx_next;
  tx_state_t tx_state, tx_next;
  logic [31:0] sr, sr_nx;
  logic [15:0] hdr, hdr_nx;
  logic [7:0]  pbyte, pbyte_nx, rssi_q, rem, drop_cnt, head;
  logic [6:0]  chan_q;
  logic [3:0]  bit_cnt;
  logic [5:0]  byte_cnt, len_q, len_nx;
  ptr_t        wp, cwp, rp, wp_nx, used;
  addr_t       wa;
  logic [7:0]  mem [FIFO_DEPTH];
  logic        ch_ok, len_bad, no_room, capture, hdr_wr, pay_wr, commit, rollback, drop;
  logic        first_q, fire;

  assign sr_nx    = {bus.serial_i, sr[31:1]};
  assign hdr_nx   = {bus.serial_i, hdr[15:1]};
  assign pbyte_nx = {bus.serial_i, pbyte[7:1]};
  assign len_nx   = hdr_nx[13:8];
  assign ch_ok    = (bus.channel_i <= 7'd78) && MASK_EXT[bus.channel_i];
  assign used     = wp - rp;
  assign len_bad  = int'(len_nx) > MAX_LEN;
  // space is judged against the registered read pointer, so a same-cycle read is not credited
  assign no_room  = int'(len_nx) + 5 > FIFO_DEPTH - int'(used);
  assign wa       = wp[AW-1:0];
  assign head     = mem[rp[AW-1:0]];
  assign wp_nx    = wp + (hdr_wr ? ptr_t'(5) : pay_wr ? ptr_t'(1) : ptr_t'(0));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_state <= RX_HUNT;
      tx_state <= TX_IDLE;
    end else begin
      rx_state <= rx_next;
      tx_state <= tx_next;
    end
  end

  always_comb begin
    rx_next  = rx_state;
    capture  = 1'b0;
    hdr_wr   = 1'b0;
    pay_wr   = 1'b0;
    commit   = 1'b0;
    rollback = 1'b0;
    drop     = 1'b0;
    case (rx_state)
      RX_HUNT:
        if (bus.valid_i && sr_nx == ACCESS_ADDR) begin
          capture = 1'b1;
          if (ch_ok) rx_next = RX_HEADER;
        end
      RX_HEADER:
        if (!bus.valid_i) begin
          rollback = 1'b1;
          rx_next  = RX_HUNT;
        end else if (bit_cnt == 4'd15) begin
          if (len_bad || no_room) begin
            drop    = 1'b1;
            rx_next = RX_HUNT;
          end else begin
            hdr_wr = 1'b1;
            if (len_nx == 6'd0) begin
              commit  = 1'b1;
              rx_next = RX_HUNT;
            end else begin
              rx_next = RX_PAYLOAD;
            end
          end
        end
      RX_PAYLOAD:
        if (!bus.valid_i) begin
          rollback = 1'b1;
          rx_next  = RX_HUNT;
        end else if (bit_cnt[2:0] == 3'd7) begin
          pay_wr = 1'b1;
          if (byte_cnt + 6'd1 == len_q) begin
            commit  = 1'b1;
            rx_next = RX_HUNT;
          end
        end
      default: rx_next = RX_HUNT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr <= '0; hdr <= '0; pbyte <= '0; bit_cnt <= '0; byte_cnt <= '0; len_q <= '0;
      chan_q <= '0; rssi_q <= '0; wp <= '0; cwp <= '0; drop_cnt <= '0;
    end else begin
      // the hunt register restarts from zero whenever a match is consumed
      if (rx_state == RX_HUNT && bus.valid_i) sr <= capture ? '0 : sr_nx;
      if (capture) begin
        chan_q <= bus.channel_i;
        rssi_q <= bus.rssi_i;
      end
      if (rx_next != rx_state) begin
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end else if (rx_state != RX_HUNT && bus.valid_i) begin
        bit_cnt <= bit_cnt + 4'd1;
        if (pay_wr) byte_cnt <= byte_cnt + 6'd1;
      end
      if (rx_state == RX_HEADER && bus.valid_i) hdr <= hdr_nx;
      if (rx_state == RX_PAYLOAD && bus.valid_i) pbyte <= pbyte_nx;
      if (hdr_wr) len_q <= len_nx;
      if (rollback) wp <= cwp;
      else          wp <= wp_nx;
      if (commit) cwp <= wp_nx;
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (hdr_wr) begin
      mem[wa]              <= 8'(len_nx) + 8'd5;
      mem[wa + addr_t'(1)] <= rssi_q;
      mem[wa + addr_t'(2)] <= {1'b0, chan_q};
      mem[wa + addr_t'(3)] <= hdr_nx[7:0];
      mem[wa + addr_t'(4)] <= hdr_nx[15:8];
    end else if (pay_wr) begin
      mem[wa] <= pbyte_nx;
    end
  end

  assign fire = (tx_state == TX_SEND) && bus.ready_i;

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE: if (cwp != rp) tx_next = TX_SEND;
      TX_SEND: if (fire && !first_q && rem == 8'd1) tx_next = TX_IDLE;
      default: tx_next = TX_IDLE;
    endcase
  end

  // the first byte of each frame is its own length and seeds the countdown
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rp      <= '0;
      rem     <= '0;
      first_q <= 1'b0;
    end else begin
      if (tx_state == TX_IDLE && tx_next == TX_SEND) first_q <= 1'b1;
      if (fire) begin
        rp      <= rp + ptr_t'(1);
        first_q <= 1'b0;
        rem     <= first_q ? head - 8'd1 : rem - 8'd1;
      end
    end
  end

  assign bus.valid_o    = (tx_state == TX_SEND);
  assign bus.frame_o    = (tx_state == TX_SEND);
  assign bus.data_o     = (tx_state == TX_SEND) ? head : 8'd0;
  assign bus.drop_cnt_o = drop_cnt;
endmodule

// File: tb/tb_ble_packet_framer.sv
// Randomized scoreboard bench for ble_packet_framer: packets are modelled as
// whole frames pushed to a byte queue; a negedge monitor pops on each handshake.
module tb_ble_packet_framer;
  localparam int          DEPTH = 64;
  localparam logic [31:0] AA    = 32'h8E89BED6;
  localparam logic [78:0] MASK  = ~(79'd1 << 38);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ble_packet_framer_if bus();

  ble_packet_framer #(
    .FIFO_DEPTH(DEPTH), .ACCESS_ADDR(AA), .CHANNEL_MASK(MASK), .MAX_LEN(37)
  ) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus.slave)
  );

  int         n_checks = 0;
  int         n_err    = 0;
  logic [7:0] exp_q[$];
  bit         last_q[$];
  int         model_drops = 0;
  int         ready_mode  = 1;
  bit         gap_due     = 0;
  bit         prev_hold   = 0;
  logic [7:0] prev_data   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ready_i driver: 0 = held low, 1 = held high, 2 = random, 3 = repeating 1,0,0,1
  initial begin
    int p = 0;
    bit [3:0] patt = 4'b1001;
    bus.ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: bus.ready_i = 1'b0;
        1: bus.ready_i = 1'b1;
        2: bus.ready_i = 1'($urandom_range(0, 1));
        default: begin bus.ready_i = patt[p % 4]; p++; end
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      gap_due   = 0;
      prev_hold = 0;
    end else begin
      if (gap_due) begin
        chk("gap_after_frame", int'(bus.valid_o), 0);
        gap_due = 0;
      end
      if (prev_hold) begin
        chk("hold_valid", int'(bus.valid_o), 1);
        chk("hold_data", int'(bus.data_o), int'(prev_data));
      end
      prev_hold = 0;
      if (bus.valid_o) begin
        chk("frame_o", int'(bus.frame_o), 1);
        if (bus.ready_i) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_byte", int'(bus.data_o) + 256, -1);
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            gap_due = last_q.pop_front();
            chk("data", int'(bus.data_o), int'(e));
          end
        end else begin
          prev_hold = 1;
          prev_data = bus.data_o;
        end
      end
    end
  end

  task automatic cycle_out(input logic b, input logic v);
    bus.serial_i = b;
    bus.valid_i  = v;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle_out(1'b0, 1'b0);
  endtask

  // abort_at: index of the post-address bit at which carrier drops (-1 = never)
  task automatic send_pkt(input int ch, input logic [7:0] rssi, input logic [7:0] h0,
                          input logic [7:0] h1, input int abort_at, input bit seq_pl);
    logic [7:0] pl[$];
    logic [7:0] b;
    logic [31:0] aa;
    int len, total;
    bit ch_ok;
    aa    = AA;
    len   = int'(h1[5:0]);
    total = 16 + 8 * len;
    for (int i = 0; i < len; i++) pl.push_back(seq_pl ? 8'(i + 1) : 8'($urandom));
    ch_ok = (ch <= 78) && (ch != 38);
    if (ch_ok && !(abort_at >= 0 && abort_at < 16)) begin
      if (len > 37 || exp_q.size() + 5 + len > DEPTH) begin
        if (model_drops < 255) model_drops++;
      end else if (!(abort_at >= 0 && abort_at < total)) begin
        exp_q.push_back(8'(5 + len)); last_q.push_back(0);
        exp_q.push_back(rssi);        last_q.push_back(0);
        exp_q.push_back(8'(ch));      last_q.push_back(0);
        exp_q.push_back(h0);          last_q.push_back(0);
        exp_q.push_back(h1);          last_q.push_back(len == 0);
        for (int i = 0; i < len; i++) begin
          exp_q.push_back(pl[i]);
          last_q.push_back(i == len - 1);
        end
      end
    end
    bus.channel_i = 7'(ch);
    bus.rssi_i    = rssi;
    for (int i = 0; i < 32; i++) cycle_out(aa[i], 1'b1);
    for (int i = 0; i < total; i++) begin
      if (i == abort_at) begin
        idle(1);
        return;
      end
      if (i < 8)       b = h0;
      else if (i < 16) b = h1;
      else             b = pl[(i - 16) / 8];
      cycle_out(b[i % 8], 1'b1);
    end
    bus.valid_i = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit && exp_q.size() != 0; i++) @(posedge clk);
    chk("drain", exp_q.size(), 0);
    @(negedge clk); @(negedge clk);
  endtask

  task automatic check_drops();
    @(negedge clk);
    chk("drop_cnt", int'(bus.drop_cnt_o), model_drops);
  endtask

  initial begin
    int cnt;
    bus.serial_i = 0; bus.valid_i = 0; bus.channel_i = 0; bus.rssi_i = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", int'(bus.valid_o), 0);
    chk("rst_frame", int'(bus.frame_o), 0);
    chk("rst_data", int'(bus.data_o), 0);
    chk("rst_drop", int'(bus.drop_cnt_o), 0);
    @(posedge clk); #1 rst = 1'b0;
    idle(2);

    // basic frame, latency and frame length
    send_pkt(37, 8'hA5, 8'h40, 8'h06, -1, 1);
    @(negedge clk); chk("lat_idle", int'(bus.valid_o), 0);
    @(negedge clk); chk("lat_first", int'(bus.valid_o), 1);
    cnt = 0;
    for (int i = 0; i < 40 && bus.frame_o; i++) begin cnt++; @(negedge clk); end
    chk("frame_cycles", cnt, 11);
    wait_drain(200);

    // masked channel then enabled neighbour
    send_pkt(38, 8'h33, 8'h42, 8'h04, -1, 0);
    idle(3);
    send_pkt(39, 8'h44, 8'h42, 8'h05, -1, 0);
    check_drops();
    wait_drain(300);

    // carrier loss after payload byte 3
    send_pkt(12, 8'h10, 8'h02, 8'h06, 16 + 24, 0);
    send_pkt(12, 8'h11, 8'h02, 8'h02, -1, 0);
    check_drops();
    wait_drain(300);

    // backpressure 1-0-0-1
    ready_mode = 3;
    send_pkt(37, 8'hA5, 8'h40, 8'h06, -1, 1);
    wait_drain(400);

    // space and length drops with output stalled
    ready_mode = 0;
    idle(2);
    send_pkt(5, 8'h77, 8'h00, 8'h25, -1, 0);
    send_pkt(6, 8'h78, 8'h00, 8'h25, -1, 0);
    send_pkt(7, 8'h79, 8'h00, 8'h25, -1, 0);
    check_drops();
    send_pkt(8, 8'h7A, 8'h00, 8'h28, -1, 0);
    check_drops();
    chk("drop_cnt_abs", int'(bus.drop_cnt_o), 3);
    ready_mode = 1;
    wait_drain(500);

    // reset in the middle of an outgoing frame
    send_pkt(20, 8'h5A, 8'h01, 8'h14, -1, 0);
    cnt = 0;
    while (!bus.valid_o && cnt < 50) begin @(posedge clk); #1; cnt++; end
    chk("mid_frame_started", int'(bus.valid_o), 1);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete(); last_q.delete(); model_drops = 0;
    @(negedge clk);
    chk("post_rst_valid", int'(bus.valid_o), 0);
    chk("post_rst_frame", int'(bus.frame_o), 0);
    chk("post_rst_data", int'(bus.data_o), 0);
    chk("post_rst_drop", int'(bus.drop_cnt_o), 0);
    cnt = 0;
    repeat (8) begin @(negedge clk); if (bus.valid_o) cnt++; end
    chk("no_residual", cnt, 0);
    #1;
    send_pkt(37, 8'hA5, 8'h40, 8'h06, -1, 1);
    wait_drain(200);

    // randomized traffic with random backpressure
    ready_mode = 2;
    for (int n = 0; n < 30; n++) begin
      int ch, len, ab;
      logic [7:0] h1;
      for (int i = 0; i < 2000 && exp_q.size() > 22; i++) @(posedge clk);
      if (exp_q.size() > 22) chk("space_wait", exp_q.size(), 22);
      #1;
      ch  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(79, 127)) : int'($urandom_range(0, 78));
      len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(38, 63)) : int'($urandom_range(0, 37));
      h1  = {2'($urandom), 6'(len)};
      ab  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 15 + 8 * len)) : -1;
      send_pkt(ch, 8'($urandom), 8'($urandom), h1, ab, 0);
      idle(int'($urandom_range(0, 3)));
    end
    check_drops();
    wait_drain(3000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_err);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ble_packet_framer.md
# ble_packet_framer

Parametrised next-generation BLE advertising packet capture stage. Receives the bit-serial demodulated stream (`serial_i`/`valid_i` with `channel_i`, `rssi_i`), hunts a programmable access address, applies a per-channel enable mask, stores each packet store-and-forward in a byte FIFO and emits it as a length-prefixed byte frame toward the USB side with `ready_i` backpressure. It replaces the fixed-width, no-backpressure analyzer output path.

## Interface
- `FIFO_DEPTH`, 128: byte FIFO depth, power of two, ≥ 64
- `ACCESS_ADDR`, 32'h8E89BED6: access address to hunt
- `CHANNEL_MASK`, all ones (79 bits): bit n = 1 enables channel n
- `MAX_LEN`, 37: maximum accepted PDU payload length in bytes
- `clk_i`  in  1  single clock
- `rst_i`  in  1  reset, synchronous, active-high
- `serial_i`  in  1  received bit, LSB-first air order
- `valid_i`  in  1  `serial_i` carries a bit this cycle; low = carrier lost
- `channel_i`  in  7  RF channel index 0..78
- `rssi_i`  in  8  signal strength
- `ready_i`  in  1  consumer accepts a byte
- `data_o`  out  8  output byte
- `valid_o`  out  1  `data_o` valid
- `frame_o`  out  1  high from first to last byte of a frame
- `drop_cnt_o`  out  8  saturating count of dropped packets

## Operation
- Receive FSM: HUNT → HEADER → PAYLOAD → HUNT.
- HUNT: each valid bit shifts into a 32-bit register at MSB (shift right). When the register equals `ACCESS_ADDR`, sample `channel_i`, `rssi_i` that cycle. If `channel_i` > 78 or `CHANNEL_MASK[channel_i]` = 0: stay in HUNT, register cleared. Else → HEADER.
- HEADER: collect 16 bits LSB-first. Byte0 = PDU header, byte1 bits[5:0] = len. len > `MAX_LEN` → drop. Free space < 5 + len → drop. Else tentatively write L = 5 + len, rssi, channel, header byte0, header byte1 at the uncommitted write pointer; → PAYLOAD (len = 0 commits immediately, → HUNT).
- PAYLOAD: assemble bytes LSB-first, tentatively write each completed byte; after byte len, commit (committed pointer ← tentative pointer), → HUNT. No CRC handling; bits after payload are treated as hunt input.
- `valid_i` low in HEADER or PAYLOAD: abort, tentative pointer rolled back to committed pointer, → HUNT, not counted as drop.
- Drop (length or space): discard, `drop_cnt_o` += 1 saturating at 255, → HUNT.
- Output FSM: IDLE → SEND. In IDLE with ≥ 1 committed byte, → SEND. SEND: `valid_o` = `frame_o` = 1, `data_o` = FIFO head; byte consumed when `valid_o` & `ready_i`. First byte gives L; after L bytes accepted → IDLE.
- Read and write in same cycle permitted; free space accounts for read pointer of that cycle's previous value (conservative).

## Timing
- Reset: HUNT, IDLE, FIFO empty, shift register 0, `data_o` = 0, `valid_o` = 0, `frame_o` = 0, `drop_cnt_o` = 0. Reset mid-frame discards all stored data.
- One bit processed per cycle with `valid_i` high; cycles with `valid_i` low in HUNT are ignored (register retained).
- First `valid_o` two cycles after the cycle sampling the last payload bit, if output IDLE and FIFO held no other frame.
- `data_o`, `valid_o`, `frame_o` stable while `valid_o` & !`ready_i`.
- `frame_o` and `valid_o` fall the cycle after the last byte accepted; at least one low cycle between frames.
- Pointers wrap modulo `FIFO_DEPTH`; full = FIFO_DEPTH bytes stored.

## Test plan
- Channel 37, rssi 0xA5, header 0x40 0x06, payload 01..06, `ready_i` = 1 → frame 0B A5 25 40 06 01 02 03 04 05 06, 11 cycles of `frame_o`.
- `CHANNEL_MASK` bit 38 cleared, valid packet on channel 38 → no output, `drop_cnt_o` = 0; following channel 39 packet output intact.
- `valid_i` low after payload byte 3 of len 6, then a full len 2 packet → only the 7-byte frame of the second packet.
- `ready_i` toggling 1-0-0-1 during frame → each byte held while not ready, sequence identical to scenario 1.
- `FIFO_DEPTH` = 64, `ready_i` = 0, three len-37 packets → first stored, next two dropped, `drop_cnt_o` = 2; release `ready_i` → one 42-byte frame. Len field 40 → dropped, counter +1.
- Assert `rst_i` one cycle mid-frame → all outputs 0 next cycle, no residual bytes; next packet framed correctly.
